// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one outstanding transaction, with a timeout error response.
// Optional build macro DMEM_ARB_RR_EN selects round-robin tie-breaking; otherwise requester 0 wins ties.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_addr,
  input  logic [31:0] i_req0_wdata,
  input  logic [3:0]  i_req0_mask,
  input  logic        i_req0_wen,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_addr,
  input  logic [31:0] i_req1_wdata,
  input  logic [3:0]  i_req1_mask,
  input  logic        i_req1_wen,
  output logic        o_rsp0_valid,
  output logic [31:0] o_rsp0_rdata,
  output logic        o_rsp0_err,
  output logic        o_rsp1_valid,
  output logic [31:0] o_rsp1_rdata,
  output logic        o_rsp1_err,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_rvalid,
  output logic        o_grant,
  output logic        o_busy
);
  // Handshake: a request transfers on a rising edge where valid and ready are both high;
  // ready is only ever offered in IDLE, so a requester simply holds valid and its payload until then.
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        wen_q, wen_d;
  logic        owner_q, owner_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        any_req, winner, timeout, in_idle, in_issue, in_resp;

  assign any_req  = i_req0_valid | i_req1_valid;
  assign timeout  = (cnt_q == CNT_LAST);
  assign in_idle  = (state_q == ST_IDLE);
  assign in_issue = (state_q == ST_ISSUE);
  assign in_resp  = (state_q == ST_RESP);

`ifdef DMEM_ARB_RR_EN
  // ptr_q names the requester preferred on a tie; it moves to the other side on every grant.
  logic ptr_q, ptr_d;
  assign winner = (i_req0_valid & i_req1_valid) ? ptr_q : ~i_req0_valid;
  assign ptr_d  = (in_idle && any_req) ? ~winner : ptr_q;
`else
  assign winner = ~i_req0_valid;
`endif

  assign o_req0_ready = i_rst_n & in_idle & i_req0_valid & ~winner;
  assign o_req1_ready = i_rst_n & in_idle & i_req1_valid & winner;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    wen_d   = wen_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          addr_d  = winner ? i_req1_addr[31:2] : i_req0_addr[31:2];
          wdata_d = winner ? i_req1_wdata : i_req0_wdata;
          mask_d  = winner ? i_req1_mask : i_req0_mask;
          wen_d   = winner ? i_req1_wen : i_req0_wen;
          owner_d = winner;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        if (i_dmem_ready) begin
          state_d = wen_q ? ST_RESP : ST_WAIT;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Data arriving on the last allowed cycle still counts as a good response.
        if (i_dmem_rvalid) begin
          rdata_d = i_dmem_rdata;
          state_d = ST_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      wen_q   <= 1'b0;
      owner_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef DMEM_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      wen_q   <= wen_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef DMEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign o_dmem_addr  = in_issue ? {addr_q, 2'b00} : 32'h0;
  assign o_dmem_wdata = in_issue ? wdata_q : 32'h0;
  assign o_dmem_mask  = in_issue ? mask_q : 4'h0;
  assign o_dmem_ren   = in_issue & ~wen_q;
  assign o_dmem_wen   = in_issue & wen_q;

  assign o_rsp0_valid = in_resp & ~owner_q;
  assign o_rsp1_valid = in_resp & owner_q;
  assign o_rsp0_rdata = o_rsp0_valid ? rdata_q : 32'h0;
  assign o_rsp1_rdata = o_rsp1_valid ? rdata_q : 32'h0;
  assign o_rsp0_err   = o_rsp0_valid & err_q;
  assign o_rsp1_err   = o_rsp1_valid & err_q;

  assign o_grant = owner_q;
  assign o_busy  = ~in_idle;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, max cycles waited in ISSUE or WAIT before an error response (legal range 2..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_req0_valid / i_req1_valid  input  1 each  request valid; requester 0 is the load/store unit, requester 1 is the secondary master.
REQ-005 o_req0_ready / o_req1_ready  output  1 each  request accepted this cycle.
REQ-006 i_reqN_addr  input  32  byte address; i_reqN_wdata  input  32  store data; i_reqN_mask  input  4  byte enables; i_reqN_wen  input  1  1=write, 0=read.
REQ-007 o_rspN_valid  output  1  one-cycle response pulse; o_rspN_rdata  output  32  read data; o_rspN_err  output  1  timeout flag.
REQ-008 o_dmem_addr  output  32; o_dmem_wdata  output  32; o_dmem_mask  output  4; o_dmem_ren, o_dmem_wen  output  1 each.
REQ-009 i_dmem_ready  input  1  memory accepts the current ren/wen; i_dmem_rdata  input  32; i_dmem_rvalid  input  1  read data valid.
REQ-010 o_grant  output  1  index of current/last owner; o_busy  output  1  high in any state other than IDLE.

Function
REQ-011 FSM states: IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-012 IDLE: if any i_reqN_valid, winner's o_reqN_ready is driven high combinationally in the same cycle; addr/wdata/mask/wen/owner captured; next state ISSUE.
REQ-013 o_reqN_ready is low in every state other than IDLE and is never high for both requesters.
REQ-014 ISSUE: o_dmem_addr = {captured_addr[31:2],2'b00}, wdata/mask from capture, o_dmem_ren = ~wen, o_dmem_wen = wen; held stable until i_dmem_ready sampled high.
REQ-015 ISSUE with i_dmem_ready high: write -> RESP; read -> WAIT; o_dmem_ren/wen low from the next cycle.
REQ-016 WAIT: on i_dmem_rvalid, capture i_dmem_rdata, next state RESP with err=0.
REQ-017 RESP: owner's o_rspN_valid high exactly one cycle; rdata = captured data (0 for writes); next state IDLE; other requester's rsp outputs stay 0.
REQ-018 Timeout: cycle counter cleared on entry to ISSUE, increments each cycle in ISSUE/WAIT; reaching TIMEOUT_CYCLES -> RESP with err=1, rdata=0, dmem strobes dropped.
REQ-019 i_dmem_rvalid outside WAIT (including after a timeout) is ignored.
REQ-020 Latency: accept at T, ready at T+1, rvalid at T+2 -> o_rspN_valid at T+3; write accepted at T with ready at T+1 -> response at T+2.
REQ-021 A new request is accepted no earlier than the cycle after RESP.
REQ-022 o_rspN_rdata/o_rspN_err are 0 whenever o_rspN_valid is low.

Reset
REQ-023 i_rst_n low forces state IDLE, all outputs 0, captured registers 0, counter 0, o_grant 0, priority pointer to "requester 0 preferred", independent of clk.
REQ-024 Reset mid-transaction drops the transaction with no response; deasserted reset resumes in IDLE.

Configuration
REQ-025 Macro DMEM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted last wins; pointer updates on each grant.
REQ-026 DMEM_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; pointer logic absent.

Verification
REQ-027 Single read req0 addr 0x1006, ready at T+1, rvalid at T+2 data 0xDEADBEEF -> o_dmem_addr 0x1004, ren=1, o_rsp0_valid at T+3 with rdata 0xDEADBEEF, err 0.
REQ-028 Write req1 addr 0x20, wdata 0x12345678, mask 4'b0011, ready held low 3 cycles -> wen/addr/wdata/mask stable 4 cycles, o_rsp1_valid 1 cycle after ready, rdata 0.
REQ-029 Both valid continuously for 4 transactions -> RR_EN: grants 0,1,0,1; without macro: 0,0,0,0.
REQ-030 Read with rvalid never asserted, TIMEOUT_CYCLES=16 -> o_rspN_valid with err=1, rdata 0, 16 cycles after ISSUE entry; late rvalid ignored.
REQ-031 i_rst_n low while in WAIT -> all outputs 0 immediately, no response pulse, next request after reset accepted in IDLE.
